// File: rtl/id_stage_pipe.sv
// Decode stage: register file with write-first bypass, operand forwarding, branch compare/target, D->E pipeline register.
// Latency: comb outputs same cycle, E outputs one clk later; StallE holds and FlushE bubbles the E register.
module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            ValidD,
    input  logic [AW-1:0]   WriteRegW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            RegWriteW,
    input  logic [XLEN-1:0] ALUOutM,
    input  logic [1:0]      ForwardAD,
    input  logic [1:0]      ForwardBD,
    input  logic            StallE,
    input  logic            FlushE,
    output logic [5:0]      Op,
    output logic [5:0]      Funct,
    output logic [AW-1:0]   RsD,
    output logic [AW-1:0]   RtD,
    output logic            EqualD,
    output logic [XLEN-1:0] PCBranchD,
    output logic [XLEN-1:0] AE,
    output logic [XLEN-1:0] BE,
    output logic [XLEN-1:0] SignImmE,
    output logic [AW-1:0]   RsE,
    output logic [AW-1:0]   RtE,
    output logic [AW-1:0]   RdE,
    output logic            ValidE
);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [AW-1:0]   rs;
        logic [AW-1:0]   rt;
        logic [AW-1:0]   rd;
        logic            vld;
    } e_reg_t;

    logic [XLEN-1:0] rf [NREG];
    logic [AW-1:0]   rd_d;
    logic [XLEN-1:0] rs_dat, rt_dat, a_dat, b_dat, sign_imm;
    logic            wr_en, byp_en;
    e_reg_t          e_d, e_q;

    assign Op       = InstrD[31:26];
    assign Funct    = InstrD[5:0];
    assign RsD      = InstrD[21 +: AW];
    assign RtD      = InstrD[16 +: AW];
    assign rd_d     = InstrD[11 +: AW];
    assign sign_imm = XLEN'($signed(InstrD[15:0]));

    assign wr_en  = RegWriteW && (WriteRegW != '0);
    // Bypass is suppressed in a reset cycle, where the write itself is discarded.
    assign byp_en = wr_en && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[WriteRegW] <= ResultW;
        end
    end

    always_comb begin
        rs_dat = rf[RsD];
        rt_dat = rf[RtD];
        if (byp_en && WriteRegW == RsD) rs_dat = ResultW;
        if (byp_en && WriteRegW == RtD) rt_dat = ResultW;
        if (RsD == '0) rs_dat = '0;
        if (RtD == '0) rt_dat = '0;
    end

    always_comb begin
        case (ForwardAD)
            2'b01:   a_dat = ALUOutM;
            2'b10:   a_dat = ResultW;
            default: a_dat = rs_dat;
        endcase
        case (ForwardBD)
            2'b01:   b_dat = ALUOutM;
            2'b10:   b_dat = ResultW;
            default: b_dat = rt_dat;
        endcase
    end

    assign EqualD    = (a_dat == b_dat);
    assign PCBranchD = PCPlus4D + (sign_imm << 2);

    always_comb begin
        e_d.a   = a_dat;
        e_d.b   = b_dat;
        e_d.imm = sign_imm;
        e_d.rs  = RsD;
        e_d.rt  = RtD;
        e_d.rd  = rd_d;
        e_d.vld = ValidD;
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            e_q <= '0;
        end else if (!StallE) begin
            e_q <= e_d;
        end
    end

    assign AE       = e_q.a;
    assign BE       = e_q.b;
    assign SignImmE = e_q.imm;
    assign RsE      = e_q.rs;
    assign RtE      = e_q.rt;
    assign RdE      = e_q.rd;
    assign ValidE   = e_q.vld;

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2, >=2); AW = clog2(NREG).
REQ-003 SHALL have ports: clk  in  1  clock, rising edge.
REQ-004 SHALL have: reset  in  1  synchronous, active-high.
REQ-005 SHALL have: InstrD  in  32  decode-stage instruction; Rs=[25:21], Rt=[20:16], Rd=[15:11], Imm=[15:0], low AW bits used as addresses.
REQ-006 SHALL have: PCPlus4D  in  XLEN  PC+4 of InstrD.
REQ-007 SHALL have: ValidD  in  1  InstrD carries a real instruction.
REQ-008 SHALL have: WriteRegW  in  AW, ResultW  in  XLEN, RegWriteW  in  1  writeback port.
REQ-009 SHALL have: ALUOutM  in  XLEN  memory-stage forward value.
REQ-010 SHALL have: ForwardAD, ForwardBD  in  2 each  operand source select: 00 regfile, 01 ALUOutM, 10 ResultW, 11 regfile.
REQ-011 SHALL have: StallE  in  1  hold E registers; FlushE  in  1  bubble E registers.
REQ-012 SHALL have outputs: Op, Funct  6 each; RsD, RtD  AW each; EqualD  1; PCBranchD  XLEN (combinational).
REQ-013 SHALL have registered outputs: AE, BE, SignImmE  XLEN; RsE, RtE, RdE  AW; ValidE  1.

Function
REQ-014 Register file SHALL hold NREG x XLEN words, two async read ports (Rs, Rt), one write port written on rising clk when RegWriteW=1 and reset=0.
REQ-015 Register 0 SHALL read as 0 always; writes to it SHALL be discarded.
REQ-016 Read of address equal to WriteRegW with RegWriteW=1 (nonzero address) SHALL return ResultW in the same cycle (write-first bypass).
REQ-017 Operand A/B SHALL be the ForwardAD/BD-selected source per REQ-010, applied after the bypass of REQ-016.
REQ-018 EqualD SHALL be 1 iff selected A == selected B over all XLEN bits.
REQ-019 SignImm SHALL be Imm sign-extended to XLEN; PCBranchD = PCPlus4D + (SignImm << 2), modulo 2^XLEN.
REQ-020 On rising clk, priority: reset > FlushE > StallE > load.
REQ-021 Load: AE<=A, BE<=B, SignImmE<=SignImm, RsE/RtE/RdE<=fields, ValidE<=ValidD.
REQ-022 FlushE: all E outputs SHALL become 0 (ValidE=0); StallE ignored when FlushE=1.
REQ-023 StallE (FlushE=0): all E outputs SHALL hold; register-file write still occurs.
REQ-024 Latency: D-stage values SHALL appear on E outputs one cycle after capture.

Reset
REQ-025 Reset cycle SHALL clear every register-file entry and every E output to 0; RegWriteW during reset SHALL be ignored.
REQ-026 Reset asserted mid-stall or mid-flush SHALL take precedence; first load occurs on first edge with reset=0.
REQ-027 Combinational outputs SHALL reflect cleared register file immediately after reset edge (EqualD=1 when forward selects 00).

Verification
REQ-028 Reset, then write r5=0x1234 and read Rs=5 same cycle -> A=0x1234 via bypass; AE=0x1234 next edge.
REQ-029 Write r0=0xFFFF_FFFF, read Rs=0 -> A=0, AE=0.
REQ-030 r8=7, r9=3, ForwardBD=01, ALUOutM=7 -> EqualD=1; ForwardBD=00 -> EqualD=0.
REQ-031 Imm=0xFFFF, PCPlus4D=0x100 -> PCBranchD=0xFC; Imm=0x7FFF, PCPlus4D=0xFFFF_FFF0 -> PCBranchD=0x0001_FFEC (wrap).
REQ-032 Load valid instr, StallE=1 for 2 cycles with new InstrD -> E outputs unchanged; FlushE=1 with StallE=1 -> all E 0, ValidE=0.
REQ-033 NREG=8, XLEN=16 build: write r7, read back; address bits above AW ignored; reset mid-stall clears E outputs.
